// File: rtl/layer_pkg.sv
// layer_pkg: fixed-point word format and helpers
// shared by the layer-1 MAC datapath.
package layer_pkg;

  localparam int WORD_W = 16;
  localparam int FRAC_W = 10;

  typedef logic signed [WORD_W-1:0] word_t;

  localparam word_t ONE = 16'h0400;

  // Clamp v to the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_to_word(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      r = hi;
    else if (v < lo) r = lo;
    else             r = v;
    return r;
  endfunction

endpackage

// File: rtl/mac_row.sv
// mac_row: one output channel -- products, adder
// tree, window accumulator, bias/ReLU/saturate.
module mac_row #(
  parameter int WORD_W   = layer_pkg::WORD_W,
  parameter int FRAC_W   = layer_pkg::FRAC_W,
  parameter int IN_LANES = 3,
  parameter int ACC_W    = 40
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear_i,
  input  logic                       adv_i,
  input  logic                       acc_en_i,
  input  logic                       acc_first_i,
  input  logic                       load_en_i,
  input  logic                       relu_en_i,
  input  logic [IN_LANES*WORD_W-1:0] x_i,
  input  logic [IN_LANES*WORD_W-1:0] w_i,
  input  logic [WORD_W-1:0]          bias_i,
  output logic [WORD_W-1:0]          y_o
);
  import layer_pkg::*;

  localparam int P_W = 2 * WORD_W;

  logic [IN_LANES-1:0][P_W-1:0] p_q;
  logic [IN_LANES-1:0][P_W-1:0] p_d;
  logic signed [ACC_W-1:0]      acc_q;
  logic signed [ACC_W-1:0]      acc_d;
  logic signed [ACC_W-1:0]      sum;
  logic signed [ACC_W-1:0]      r;
  logic [WORD_W-1:0]            y_q;
  logic [WORD_W-1:0]            y_d;
  logic signed [WORD_W-1:0]     xs;
  logic signed [WORD_W-1:0]     ws;
  logic signed [WORD_W-1:0]     bs;

  always_comb begin
    xs = '0;
    ws = '0;
    for (int i = 0; i < IN_LANES; i++) begin
      xs     = x_i[i*WORD_W +: WORD_W];
      ws     = w_i[i*WORD_W +: WORD_W];
      p_d[i] = P_W'(ws) * P_W'(xs);
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < IN_LANES; i++)
      sum = sum + ACC_W'($signed(p_q[i]));
    acc_d = (acc_first_i ? '0 : acc_q) + sum;
  end

  // Floor shift back to Q(FRAC_W), then bias.
  always_comb begin
    bs = bias_i;
    r  = (acc_q >>> FRAC_W) + ACC_W'(bs);
    if (relu_en_i && r < 0)
      r = '0;
    y_d = WORD_W'(sat_to_word(64'(r), WORD_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= '0;
      acc_q <= '0;
      y_q   <= '0;
    end else begin
      if (adv_i)
        p_q <= p_d;
      if (clear_i)
        acc_q <= '0;
      else if (adv_i && acc_en_i)
        acc_q <= acc_d;
      if (adv_i && load_en_i)
        y_q <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/layer1_mac_array.sv
// layer1_mac_array: OUT_CH-row pipelined MAC with
// window accumulation and valid/ready on both sides.
module layer1_mac_array #(
  parameter int WORD_W    = layer_pkg::WORD_W,
  parameter int FRAC_W    = layer_pkg::FRAC_W,
  parameter int IN_LANES  = 3,
  parameter int OUT_CH    = 8,
  parameter int ACC_BEATS = 9,
  parameter int ACC_W     = 40
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clear,
  input  logic                              relu_en,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [IN_LANES*WORD_W-1:0]        in_data,
  input  logic [OUT_CH*IN_LANES*WORD_W-1:0] weight_data,
  input  logic [OUT_CH*WORD_W-1:0]          bias_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OUT_CH*WORD_W-1:0]          out_data,
  output logic                              busy
);
  import layer_pkg::*;

  localparam int CNT_W =
    (ACC_BEATS > 1) ? $clog2(ACC_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(ACC_BEATS - 1);
  localparam int RW = IN_LANES * WORD_W;

  logic             adv;
  logic             accept;
  logic             s2_load;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             s1_vld_q;
  logic             s1_first_q;
  logic             s1_last_q;
  logic             s2_vld_q;
  logic             s2_last_q;
  logic             out_vld_q;

  assign adv     = !out_vld_q || out_ready;
  assign accept  = in_valid && adv && !clear;
  assign s2_load = s2_vld_q && s2_last_q && !clear;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (accept)
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_vld_q   <= 1'b0;
      s2_last_q  <= 1'b0;
      out_vld_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (clear) begin
        s1_vld_q <= 1'b0;
        s2_vld_q <= 1'b0;
      end else if (adv) begin
        s1_vld_q <= accept;
        s2_vld_q <= s1_vld_q;
      end
      if (adv) begin
        s1_first_q <= (cnt_q == '0);
        s1_last_q  <= (cnt_q == LAST);
        s2_last_q  <= s1_last_q;
        out_vld_q  <= s2_load;
      end
    end
  end

  for (genvar c = 0; c < OUT_CH; c++) begin : g_row
    mac_row #(
      .WORD_W   (WORD_W),
      .FRAC_W   (FRAC_W),
      .IN_LANES (IN_LANES),
      .ACC_W    (ACC_W)
    ) u_row (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_i     (clear),
      .adv_i       (adv),
      .acc_en_i    (s1_vld_q),
      .acc_first_i (s1_first_q),
      .load_en_i   (s2_load),
      .relu_en_i   (relu_en),
      .x_i         (in_data),
      .w_i         (weight_data[c*RW +: RW]),
      .bias_i      (bias_data[c*WORD_W +: WORD_W]),
      .y_o         (out_data[c*WORD_W +: WORD_W])
    );
  end

  assign in_ready  = adv;
  assign out_valid = out_vld_q;
  assign busy      = (cnt_q != '0) || s1_vld_q || s2_vld_q;

endmodule
